// File: rtl/fwb_queue.sv
// FPU register-file write front end: primary writeback has priority on the single
// write port, long-latency results queue in a small FIFO and drain when it is idle.
module fwb_queue #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pwe,
    input  logic [4:0]                   pa,
    input  logic [FLEN-1:0]              pd,
    input  logic                         svalid,
    output logic                         sready,
    input  logic [4:0]                   sa,
    input  logic [FLEN-1:0]              sd,
    output logic                         we4,
    output logic [4:0]                   a4,
    output logic [FLEN-1:0]              wd4,
    output logic [31:0]                  pending,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] live_r;
    logic [4:0]       addr_r [DEPTH];
    logic [FLEN-1:0]  data_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             we4_r;
    logic [4:0]       a4_r;
    logic [FLEN-1:0]  wd4_r;

    logic             full_s;
    logic             empty_s;
    logic             hs_s;
    logic             push_s;
    logic             pop_s;
    logic             push_live_s;
    logic             nxt_we_s;
    logic [4:0]       nxt_a_s;
    logic [FLEN-1:0]  nxt_d_s;
    logic [31:0]      pending_s;

    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        onehot32 = 32'd1 << idx;
    endfunction

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign hs_s    = svalid && !full_s;

    // Port arbitration: primary first, then live head, then empty-FIFO bypass.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_live_s = 1'b1;
        nxt_we_s    = 1'b0;
        nxt_a_s     = a4_r;
        nxt_d_s     = wd4_r;
        if (pwe) begin
            nxt_we_s    = 1'b1;
            nxt_a_s     = pa;
            nxt_d_s     = pd;
            // A squashed head still leaves the queue while the primary owns the port.
            pop_s       = !empty_s && !live_r[rd_ptr_r];
            push_s      = hs_s;
            push_live_s = (sa != pa);
        end else if (!empty_s) begin
            pop_s  = 1'b1;
            push_s = hs_s;
            if (live_r[rd_ptr_r]) begin
                nxt_we_s = 1'b1;
                nxt_a_s  = addr_r[rd_ptr_r];
                nxt_d_s  = data_r[rd_ptr_r];
            end else begin
                nxt_we_s = 1'b0;
            end
        end else if (hs_s) begin
            nxt_we_s = 1'b1;
            nxt_a_s  = sa;
            nxt_d_s  = sd;
        end else begin
            nxt_we_s = 1'b0;
        end
    end

    // Control state: live bits, pointers, occupancy and the write-port register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            live_r   <= {DEPTH{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            we4_r    <= 1'b0;
            a4_r     <= 5'd0;
            wd4_r    <= {FLEN{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pwe && (addr_r[i] == pa)) begin
                    live_r[i] <= 1'b0;
                end else begin
                    live_r[i] <= live_r[i];
                end
            end
            // Popped slots are cleared so pending only ever sees occupied entries.
            if (pop_s) begin
                live_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r         <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s) begin
                live_r[wr_ptr_r] <= push_live_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            we4_r <= nxt_we_s;
            a4_r  <= nxt_a_s;
            wd4_r <= nxt_d_s;
        end
    end

    // Entry payload storage; validity is carried by live_r, so no reset needed.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            addr_r[wr_ptr_r] <= sa;
            data_r[wr_ptr_r] <= sd;
        end else begin
            addr_r[wr_ptr_r] <= addr_r[wr_ptr_r];
            data_r[wr_ptr_r] <= data_r[wr_ptr_r];
        end
    end

    // Hazard mask over queued live entries plus the write currently on the port.
    always_comb begin
        pending_s = we4_r ? onehot32(a4_r) : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s | (live_r[i] ? onehot32(addr_r[i]) : 32'd0);
        end
    end

    assign sready  = !full_s;
    assign we4     = we4_r;
    assign a4      = a4_r;
    assign wd4     = wd4_r;
    assign pending = pending_s;
    assign count   = count_r;
    assign full    = full_s;
    assign empty   = empty_s;
endmodule

// File: tb/tb_fwb_queue.sv
// Directed self-checking bench for fwb_queue (FLEN=64, DEPTH=4).
module tb_fwb_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        pwe;
    logic [4:0]  pa;
    logic [63:0] pd;
    logic        svalid;
    logic        sready;
    logic [4:0]  sa;
    logic [63:0] sd;
    logic        we4;
    logic [4:0]  a4;
    logic [63:0] wd4;
    logic [31:0] pending;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_assert = 0;
    int n_fail   = 0;
    int bad_wr7  = 0;
    int bad_wrq  = 0;

    localparam logic [63:0] DP = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DA = 64'hAAAA_0000_0000_0007;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_0007;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_0008;

    fwb_queue #(.FLEN(64), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pwe(pwe), .pa(pa), .pd(pd),
        .svalid(svalid), .sready(sready), .sa(sa), .sd(sd),
        .we4(we4), .a4(a4), .wd4(wd4), .pending(pending),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Write-port monitors: stale squashed data to r7, and writes of discarded entries.
    always @(negedge clk) begin
        if (we4 && a4 == 5'd7 && wd4 == DA) bad_wr7++;
        if (we4 && (a4 == 5'd10 || a4 == 5'd11 || a4 == 5'd12)) bad_wrq++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; pwe = 1'b0; pa = 5'd0; pd = 64'd0;
        svalid = 1'b0; sa = 5'd0; sd = 64'd0;
        step(); step();
        reset = 1'b1;
        step();
        chk("rst_we4",     64'(we4),     64'd0);
        chk("rst_a4",      64'(a4),      64'd0);
        chk("rst_wd4",     wd4,          64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_count",   64'(count),   64'd0);
        chk("rst_empty",   64'(empty),   64'd1);
        chk("rst_full",    64'(full),    64'd0);
        chk("rst_sready",  64'(sready),  64'd1);

        // Primary latency
        pwe = 1'b1; pa = 5'd5; pd = 64'h3FF0_0000_0000_0000;
        step();
        chk("pri_we4",     64'(we4),     64'd1);
        chk("pri_a4",      64'(a4),      64'd5);
        chk("pri_wd4",     wd4,          64'h3FF0_0000_0000_0000);
        chk("pri_pending", 64'(pending), 64'h20);
        pwe = 1'b0;
        step();
        chk("pri_we4_off", 64'(we4),     64'd0);
        chk("pri_a4_hold", 64'(a4),      64'd5);
        chk("pri_pend_off",64'(pending), 64'd0);

        // Bypass
        svalid = 1'b1; sa = 5'd9; sd = 64'h4000_0000_0000_0000;
        step();
        chk("byp_we4",     64'(we4),     64'd1);
        chk("byp_a4",      64'(a4),      64'd9);
        chk("byp_wd4",     wd4,          64'h4000_0000_0000_0000);
        chk("byp_count",   64'(count),   64'd0);
        chk("byp_pending", 64'(pending), 64'h200);
        svalid = 1'b0;
        step();
        chk("byp_we4_off", 64'(we4),     64'd0);
        chk("byp_pend_off",64'(pending), 64'd0);

        // Fill behind a primary stream to reg 20, then drain
        pwe = 1'b1; pa = 5'd20; pd = DP;
        for (int i = 1; i <= 4; i++) begin
            svalid = 1'b1; sa = 5'(i); sd = 64'(i) + 64'h10;
            step();
            chk("fill_count", 64'(count), 64'(i));
        end
        chk("fill_full",    64'(full),    64'd1);
        chk("fill_sready",  64'(sready),  64'd0);
        chk("fill_pending", 64'(pending), 64'h0010_001E);
        chk("fill_we4_pri", 64'(we4),     64'd1);
        sa = 5'd30;
        step();
        chk("full_nopush",  64'(count),   64'd4);
        chk("full_nopend",  64'(pending), 64'h0010_001E);
        svalid = 1'b0; pwe = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_we4",   64'(we4),   64'd1);
            chk("drain_a4",    64'(a4),    64'(i));
            chk("drain_wd4",   wd4,        64'(i) + 64'h10);
            chk("drain_count", 64'(count), 64'(4 - i));
        end
        chk("drain_pend_last", 64'(pending), 64'h10);
        step();
        chk("drain_we4_off", 64'(we4),     64'd0);
        chk("drain_empty",   64'(empty),   64'd1);
        chk("drain_pending", 64'(pending), 64'd0);

        // WAW squash
        pwe = 1'b1; pa = 5'd20; pd = DP;
        svalid = 1'b1; sa = 5'd7; sd = DA;
        step();
        chk("sq_count1", 64'(count), 64'd1);
        sa = 5'd8; sd = DC;
        step();
        chk("sq_count2",  64'(count),   64'd2);
        chk("sq_pend2",   64'(pending), 64'h0010_0180);
        svalid = 1'b0; pa = 5'd7; pd = DB;
        step();
        chk("sq_we4",     64'(we4),     64'd1);
        chk("sq_a4",      64'(a4),      64'd7);
        chk("sq_wd4",     wd4,          DB);
        chk("sq_count3",  64'(count),   64'd2);
        chk("sq_pend3",   64'(pending), 64'h180);
        pwe = 1'b0;
        step();
        chk("sq_dead_we4",  64'(we4),     64'd0);
        chk("sq_dead_cnt",  64'(count),   64'd1);
        chk("sq_dead_pend", 64'(pending), 64'h100);
        step();
        chk("sq_w8_we4",  64'(we4),   64'd1);
        chk("sq_w8_a4",   64'(a4),    64'd8);
        chk("sq_w8_wd4",  wd4,        DC);
        chk("sq_w8_cnt",  64'(count), 64'd0);
        step();
        chk("sq_idle_we4", 64'(we4),   64'd0);
        chk("sq_no_stale", 64'(bad_wr7), 64'd0);

        // Reset mid-drain
        pwe = 1'b1; pa = 5'd20; pd = DP;
        for (int i = 10; i <= 12; i++) begin
            svalid = 1'b1; sa = 5'(i); sd = 64'(i);
            step();
        end
        chk("rmd_count", 64'(count), 64'd3);
        pwe = 1'b0; svalid = 1'b0; reset = 1'b0;
        step();
        chk("rmd_we4",     64'(we4),     64'd0);
        chk("rmd_count0",  64'(count),   64'd0);
        chk("rmd_pending", 64'(pending), 64'd0);
        chk("rmd_empty",   64'(empty),   64'd1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rmd_idle_we4", 64'(we4), 64'd0);
        end
        chk("rmd_no_write", 64'(bad_wrq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
